// File: rtl/tc_sram_march_bist.sv
// ============================================================================
// Module  : tc_sram_march_bist
// Purpose : March C- built-in self-test initiator for a tc_sram request/
//           response port. Runs M0..M5 with all-zero / all-ones backgrounds,
//           compares returning read data and reports pass/fail, the first
//           failing address and a saturating mismatch count.
// Ports   : clk_i, rst_i (async, active high), start_i
//           busy_o, done_o, fail_o, fail_addr_o, fail_cnt_o   - status/result
//           req_o, we_o, addr_o, wdata_o, be_o                - SRAM request
//           rdata_i                                           - SRAM read data
// Config  : define SRAM_BIST_STOP_ON_FAIL_EN to end the run at the first
//           mismatch (outstanding compares discarded, FSM goes to DONE).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_sram_march_bist #(
  parameter int NumWords     = 1024,
  parameter int DataWidth    = 128,
  parameter int ByteWidth    = 8,
  parameter int Latency      = 1,
  parameter int FailCntWidth = 8,
  parameter int AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [AddrWidth-1:0]    fail_addr_o,
  output logic [FailCntWidth-1:0] fail_cnt_o,
  output logic                    req_o,
  output logic                    we_o,
  output logic [AddrWidth-1:0]    addr_o,
  output logic [DataWidth-1:0]    wdata_o,
  output logic [(DataWidth+ByteWidth-1)/ByteWidth-1:0] be_o,
  input  logic [DataWidth-1:0]    rdata_i
);

  localparam int CntWidth = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(NumWords - 1);
  localparam logic [CntWidth-1:0]  DrainLast = CntWidth'((Latency > 0) ? Latency - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [2:0]            elem;        // march element 0..5 of the next op
  logic [AddrWidth-1:0]  idx;         // position within the element (0 = first)
  logic                  phase;       // 0 = read half, 1 = write half of a two-op element
  logic                  last_issued; // the op currently on the bus is the final one
  logic                  exp_bit;     // background of the read currently on the bus
  logic [CntWidth-1:0]   drain_cnt;

  // Decode of the next op from the element/index/phase counters.
  logic                  two_op, op_down, op_we, op_bit, op_last;
  logic [AddrWidth-1:0]  op_addr;

  always_comb begin
    two_op  = (elem >= 3'd1) && (elem <= 3'd4);
    op_down = (elem == 3'd3) || (elem == 3'd4);
    op_we   = (elem == 3'd0) || (two_op && phase);
    case (elem)
      3'd1, 3'd3: op_bit = phase;   // (r0,w1)
      3'd2, 3'd4: op_bit = ~phase;  // (r1,w0)
      default:    op_bit = 1'b0;    // w0 / r0
    endcase
    op_addr = op_down ? (LastAddr - idx) : idx;
    op_last = (elem == 3'd5) && (idx == LastAddr);
  end

  // Compare point: either the request itself (zero latency) or the tail of
  // a Latency-deep pipeline loaded on every read request.
  logic                  cmp_valid;
  logic [AddrWidth-1:0]  cmp_addr;
  logic                  cmp_bit;
  logic                  mismatch;
  logic                  abort;

  generate
    if (Latency == 0) begin : g_lat0
      assign cmp_valid = req_o & ~we_o;
      assign cmp_addr  = addr_o;
      assign cmp_bit   = exp_bit;
    end else begin : g_pipe
      logic [Latency-1:0]   pv;
      logic [Latency-1:0]   pb;
      logic [AddrWidth-1:0] pa [Latency];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pv <= '0;
          pb <= '0;
          for (int k = 0; k < Latency; k++) pa[k] <= '0;
        end else begin
          pv[0] <= req_o & ~we_o & ~abort;
          pb[0] <= exp_bit;
          pa[0] <= addr_o;
          for (int k = 1; k < Latency; k++) begin
            pv[k] <= pv[k-1] & ~abort;
            pb[k] <= pb[k-1];
            pa[k] <= pa[k-1];
          end
        end
      end

      assign cmp_valid = pv[Latency-1];
      assign cmp_addr  = pa[Latency-1];
      assign cmp_bit   = pb[Latency-1];
    end
  endgenerate

  assign mismatch = cmp_valid && (rdata_i != {DataWidth{cmp_bit}});

`ifdef SRAM_BIST_STOP_ON_FAIL_EN
  assign abort = mismatch;
`else
  assign abort = 1'b0;
`endif

  // A request goes out on the start edge and on every RUN edge until the
  // final op has been on the bus for one cycle.
  logic issue;
  assign issue = (((state == S_IDLE) || (state == S_DONE)) && start_i) ||
                 ((state == S_RUN) && !last_issued && !abort);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_cnt_o  <= '0;
      req_o       <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      be_o        <= '0;
      exp_bit     <= 1'b0;
      last_issued <= 1'b0;
      elem        <= '0;
      idx         <= '0;
      phase       <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      // Bus and march counters.
      if (issue) begin
        req_o       <= 1'b1;
        we_o        <= op_we;
        addr_o      <= op_addr;
        wdata_o     <= op_we ? {DataWidth{op_bit}} : '0;
        be_o        <= '1;
        exp_bit     <= op_bit;
        last_issued <= op_last;
        if (two_op && !phase) begin
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (idx == LastAddr) begin
            idx  <= '0;
            elem <= elem + 3'd1;
          end else begin
            idx <= idx + AddrWidth'(1);
          end
        end
      end else begin
        req_o       <= 1'b0;
        we_o        <= 1'b0;
        addr_o      <= '0;
        wdata_o     <= '0;
        be_o        <= '0;
        exp_bit     <= 1'b0;
        last_issued <= 1'b0;
        elem        <= '0;
        idx         <= '0;
        phase       <= 1'b0;
      end

      // Result registers; a new run's clear below takes priority.
      if (mismatch) begin
        fail_o <= 1'b1;
        if (!fail_o) fail_addr_o <= cmp_addr;
        if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + FailCntWidth'(1);
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state       <= S_RUN;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_cnt_o  <= '0;
          end
        end
        S_RUN: begin
          if (abort || (last_issued && (Latency == 0))) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (last_issued) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (abort || (drain_cnt == DrainLast)) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CntWidth'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tc_sram_march_bist.sv
// ============================================================================
// Module  : tb_tc_sram_march_bist
// Purpose : Directed bench for tc_sram_march_bist. Three instances (read
//           latency 0, 1 and 3) run side by side, each against a small
//           behavioural SRAM with an optional stuck-at-1 on bit 3 of word 5.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tc_sram_march_bist;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 4;
  localparam int RUN_OPS = 10 * N;
  localparam int BOUND = 1000;

`ifdef SRAM_BIST_STOP_ON_FAIL_EN
  localparam int EXP_FAULT_CNT = 1;
`else
  localparam int EXP_FAULT_CNT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic fault_en = 1'b0;
  logic meas_clr = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    logic          busy, done, fail, req, we;
    logic [AW-1:0] fail_addr, addr;
    logic [7:0]    fail_cnt;
    logic [DW-1:0] wdata, rdata, rd_now;
    logic [BW-1:0] be;
    logic [DW-1:0] mem [N];

    int            req_cycles, busy_cycles, req_rises;
    logic          req_d;
    logic [AW-1:0] tr_addr [RUN_OPS];
    logic          tr_we   [RUN_OPS];
    logic [DW-1:0] tr_wd   [RUN_OPS];
    logic [BW-1:0] tr_be   [RUN_OPS];

    tc_sram_march_bist #(
      .NumWords(N), .DataWidth(DW), .ByteWidth(8), .Latency(LAT), .FailCntWidth(8)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .busy_o(busy), .done_o(done), .fail_o(fail),
      .fail_addr_o(fail_addr), .fail_cnt_o(fail_cnt),
      .req_o(req), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be),
      .rdata_i(rdata)
    );

    // Behavioural SRAM: the fault forces bit 3 of word 5 high on reads.
    assign rd_now = mem[addr] | ((fault_en && addr == AW'(5)) ? DW'(8) : {DW{1'b0}});

    always @(posedge clk) begin
      if (req && we) mem[addr] <= wdata;
    end

    if (LAT == 0) begin : g_l0
      assign rdata = rd_now;
    end else begin : g_lp
      logic [DW-1:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= rd_now;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign rdata = pipe[LAT-1];
    end

    // Run-length counters and a trace of the issued requests.
    always @(posedge clk) begin
      if (meas_clr) begin
        req_cycles  <= 0;
        busy_cycles <= 0;
        req_rises   <= 0;
        req_d       <= 1'b0;
      end else begin
        if (req)  req_cycles  <= req_cycles + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
        if (req && !req_d) req_rises <= req_rises + 1;
        req_d <= req;
        if (req && req_cycles < RUN_OPS) begin
          tr_addr[req_cycles] <= addr;
          tr_we[req_cycles]   <= we;
          tr_wd[req_cycles]   <= wdata;
          tr_be[req_cycles]   <= be;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_all_done(input string tag);
    int n = 0;
    while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < BOUND), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1; meas_clr = 1'b1;
    @(negedge clk);
    start = 1'b0; meas_clr = 1'b0;
  endtask

  initial begin
    // ---- reset state -------------------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_req",       g_inst[1].req, 0);
    check("rst_we",        g_inst[1].we, 0);
    check("rst_addr",      g_inst[1].addr, 0);
    check("rst_wdata",     g_inst[1].wdata, 0);
    check("rst_be",        g_inst[1].be, 0);
    check("rst_busy",      g_inst[1].busy, 0);
    check("rst_done",      g_inst[1].done, 0);
    check("rst_fail",      g_inst[1].fail, 0);
    check("rst_fail_addr", g_inst[1].fail_addr, 0);
    check("rst_fail_cnt",  g_inst[1].fail_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- fault-free run ----------------------------------------------------
    pulse_start();
    check("run1_busy_on", g_inst[1].busy, 1);
    check("run1_req_on",  g_inst[1].req, 1);
    wait_all_done("run1_timeout");
    check("run1_req_cycles",  g_inst[1].req_cycles, 160);
    check("run1_req_rises",   g_inst[1].req_rises, 1);
    check("run1_busy_l0",     g_inst[0].busy_cycles, 160);
    check("run1_busy_l1",     g_inst[1].busy_cycles, 161);
    check("run1_busy_l3",     g_inst[2].busy_cycles, 163);
    check("run1_done",        g_inst[1].done, 1);
    check("run1_fail",        g_inst[1].fail, 0);
    check("run1_fail_cnt",    g_inst[1].fail_cnt, 0);
    check("run1_fail_l0",     g_inst[0].fail, 0);
    check("run1_fail_l3",     g_inst[2].fail, 0);

    // ---- bus order (up w0, then (r0,w1), ..., down elements) ---------------
    check("bus0_addr",   g_inst[1].tr_addr[0], 0);
    check("bus0_we",     g_inst[1].tr_we[0], 1);
    check("bus0_wd",     g_inst[1].tr_wd[0], 32'h0);
    check("bus0_be",     g_inst[1].tr_be[0], 4'hf);
    check("bus15_addr",  g_inst[1].tr_addr[15], 15);
    check("bus16_addr",  g_inst[1].tr_addr[16], 0);
    check("bus16_we",    g_inst[1].tr_we[16], 0);
    check("bus16_wd",    g_inst[1].tr_wd[16], 32'h0);
    check("bus17_addr",  g_inst[1].tr_addr[17], 0);
    check("bus17_we",    g_inst[1].tr_we[17], 1);
    check("bus17_wd",    g_inst[1].tr_wd[17], 32'hffff_ffff);
    check("bus18_addr",  g_inst[1].tr_addr[18], 1);
    check("bus48_we",    g_inst[1].tr_we[48], 0);
    check("bus49_wd",    g_inst[1].tr_wd[49], 32'h0);
    check("bus80_addr",  g_inst[1].tr_addr[80], 15);
    check("bus80_we",    g_inst[1].tr_we[80], 0);
    check("bus81_addr",  g_inst[1].tr_addr[81], 15);
    check("bus81_wd",    g_inst[1].tr_wd[81], 32'hffff_ffff);
    check("bus82_addr",  g_inst[1].tr_addr[82], 14);
    check("bus112_addr", g_inst[1].tr_addr[112], 15);
    check("bus113_wd",   g_inst[1].tr_wd[113], 32'h0);
    check("bus159_addr", g_inst[1].tr_addr[159], 15);
    check("bus159_we",   g_inst[1].tr_we[159], 0);
    check("bus159_be",   g_inst[1].tr_be[159], 4'hf);

    // ---- stuck-at-1 on bit 3 of word 5, all latencies ----------------------
    fault_en = 1'b1;
    pulse_start();
    wait_all_done("run2_timeout");
    check("run2_fail_l0",      g_inst[0].fail, 1);
    check("run2_fail_addr_l0", g_inst[0].fail_addr, 5);
    check("run2_fail_cnt_l0",  g_inst[0].fail_cnt, EXP_FAULT_CNT);
    check("run2_fail_l1",      g_inst[1].fail, 1);
    check("run2_fail_addr_l1", g_inst[1].fail_addr, 5);
    check("run2_fail_cnt_l1",  g_inst[1].fail_cnt, EXP_FAULT_CNT);
    check("run2_fail_l3",      g_inst[2].fail, 1);
    check("run2_fail_addr_l3", g_inst[2].fail_addr, 5);
    check("run2_fail_cnt_l3",  g_inst[2].fail_cnt, EXP_FAULT_CNT);
    check("run2_done_l1",      g_inst[1].done, 1);
`ifndef SRAM_BIST_STOP_ON_FAIL_EN
    check("run2_busy_l0",      g_inst[0].busy_cycles, 160);
    check("run2_busy_l3",      g_inst[2].busy_cycles, 163);
`endif

    // ---- start held high through the run: results cleared, one run only ---
    start = 1'b1; meas_clr = 1'b1;
    @(negedge clk);
    meas_clr = 1'b0;
    check("run3_fail_clr",     g_inst[1].fail, 0);
    check("run3_fail_cnt_clr", g_inst[1].fail_cnt, 0);
    check("run3_done_clr",     g_inst[1].done, 0);
    begin
      int n = 0;
      while (!g_inst[0].done && n < BOUND) begin
        @(negedge clk);
        n++;
      end
      check("run3_first_done_timeout", 32'(n < BOUND), 1);
    end
    start = 1'b0;
    wait_all_done("run3_timeout");
    check("run3_rises_l0",    g_inst[0].req_rises, 1);
    check("run3_rises_l1",    g_inst[1].req_rises, 1);
    check("run3_rises_l3",    g_inst[2].req_rises, 1);
    check("run3_fail_cnt_l1", g_inst[1].fail_cnt, EXP_FAULT_CNT);

    // ---- asynchronous reset in the middle of a run ------------------------
    fault_en = 1'b0;
    pulse_start();
    repeat (49) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_req",  g_inst[1].req, 0);
    check("arst_busy", g_inst[1].busy, 0);
    check("arst_be",   g_inst[1].be, 0);
    check("arst_fail", g_inst[1].fail, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arst_idle_busy", g_inst[1].busy, 0);
    check("arst_idle_done", g_inst[1].done, 0);
    check("arst_idle_req",  g_inst[1].req, 0);

    // ---- clean run after the abort ----------------------------------------
    pulse_start();
    wait_all_done("run5_timeout");
    check("run5_req_cycles", g_inst[1].req_cycles, 160);
    check("run5_req_rises",  g_inst[1].req_rises, 1);
    check("run5_busy",       g_inst[1].busy_cycles, 161);
    check("run5_fail",       g_inst[1].fail, 0);
    check("run5_fail_cnt",   g_inst[1].fail_cnt, 0);
    check("run5_done",       g_inst[1].done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
